// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding and note denominations.
// Also consumed by the upstream state-transition block; keep encodings stable.
package change_dispenser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_REQ    = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } chg_state_e;

  // One-hot denomination codes as driven on disp_denom, MSB = 50 yuan.
  localparam logic [4:0] DENOM_50 = 5'b10000;
  localparam logic [4:0] DENOM_20 = 5'b01000;
  localparam logic [4:0] DENOM_10 = 5'b00100;
  localparam logic [4:0] DENOM_5  = 5'b00010;
  localparam logic [4:0] DENOM_1  = 5'b00001;

  localparam logic [7:0] VAL_50 = 8'd50;
  localparam logic [7:0] VAL_20 = 8'd20;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_1  = 8'd1;

endpackage

// File: rtl/denom_select.sv
// Greedy note selector: largest denomination not exceeding the amount still owed.
// Purely combinational; an amount of zero selects nothing.
module denom_select
  import change_dispenser_pkg::*;
(
  input  logic [7:0] i_amount,
  output logic [4:0] o_denom,
  output logic [7:0] o_value
);

  // NOTE: every output gets a default before the priority chain so no path infers a latch.
  always_comb begin
    o_denom = '0;
    o_value = '0;
    if (i_amount >= VAL_50) begin
      o_denom = DENOM_50;
      o_value = VAL_50;
    end else if (i_amount >= VAL_20) begin
      o_denom = DENOM_20;
      o_value = VAL_20;
    end else if (i_amount >= VAL_10) begin
      o_denom = DENOM_10;
      o_value = VAL_10;
    end else if (i_amount >= VAL_5) begin
      o_denom = DENOM_5;
      o_value = VAL_5;
    end else if (i_amount >= VAL_1) begin
      o_denom = DENOM_1;
      o_value = VAL_1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays an 8-bit amount as a greedy sequence of notes via a req/ack hopper.
// Optional hopper timeout with FAULT state is enabled by defining CHG_TIMEOUT_EN.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       chg_start,
  input  logic [7:0] chg_amount,
  input  logic       disp_ack,
  output logic       disp_req,
  output logic [4:0] disp_denom,
  output logic [7:0] chg_remaining,
  output logic       chg_busy,
  output logic       chg_done,
  output logic       chg_fault
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_gap_range_err
    $error("change_dispenser: GAP_CYCLES must be within 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_err
    $error("change_dispenser: TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  chg_state_e r_state, w_state_nxt;
  logic       r_req, w_req_nxt;
  logic [4:0] r_denom, w_denom_nxt;
  logic [7:0] r_value, w_value_nxt;
  logic [7:0] r_remaining, w_remaining_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic [7:0] r_gap_cnt, w_gap_nxt;
  logic [4:0] w_sel_denom;
  logic [7:0] w_sel_value;

`ifdef CHG_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt, w_to_nxt;
  logic            r_fault, w_fault_nxt;
`endif

  denom_select u_denom_select (
    .i_amount (r_remaining),
    .o_denom  (w_sel_denom),
    .o_value  (w_sel_value)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = 1'b0;
    w_denom_nxt     = '0;
    w_value_nxt     = r_value;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    w_gap_nxt       = r_gap_cnt;
`ifdef CHG_TIMEOUT_EN
    w_to_nxt        = '0;
    w_fault_nxt     = r_fault;
`endif
    case (r_state)
      ST_IDLE: begin
        if (chg_start) begin
          w_remaining_nxt = chg_amount;
          w_state_nxt     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (r_remaining == 8'd0) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_denom_nxt = w_sel_denom;
          w_value_nxt = w_sel_value;
          w_req_nxt   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (disp_ack) begin
          w_remaining_nxt = r_remaining - r_value;
          w_gap_nxt       = GAP_LOAD;
          w_state_nxt     = ST_GAP;
        end else begin
          w_req_nxt   = 1'b1;
          w_denom_nxt = r_denom;
`ifdef CHG_TIMEOUT_EN
          if (r_to_cnt == TO_LAST) begin
            w_req_nxt   = 1'b0;
            w_denom_nxt = '0;
            w_fault_nxt = 1'b1;
            w_state_nxt = ST_FAULT;
          end else begin
            w_to_nxt = r_to_cnt + 1'b1;
          end
`endif
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 8'd0) w_state_nxt = ST_SELECT;
        else                   w_gap_nxt   = r_gap_cnt - 8'd1;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
`ifdef CHG_TIMEOUT_EN
      ST_FAULT: w_state_nxt = ST_FAULT;  // only reset leaves FAULT
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // NOTE: state and registered outputs use non-blocking assignments so all update together at the edge.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_denom     <= '0;
      r_value     <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_gap_cnt   <= '0;
`ifdef CHG_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_fault     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_denom     <= w_denom_nxt;
      r_value     <= w_value_nxt;
      r_remaining <= w_remaining_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_gap_cnt   <= w_gap_nxt;
`ifdef CHG_TIMEOUT_EN
      r_to_cnt    <= w_to_nxt;
      r_fault     <= w_fault_nxt;
`endif
    end
  end

  assign disp_req      = r_req;
  assign disp_denom    = r_denom;
  assign chg_remaining = r_remaining;
  assign chg_busy      = r_busy;
  assign chg_done      = r_done;
`ifdef CHG_TIMEOUT_EN
  assign chg_fault     = r_fault;
`else
  assign chg_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a greedy payout model feeds an expectation queue
// that a negedge monitor drains on every new request and every done pulse.
module tb_change_dispenser;

  localparam int GAP = 4;
  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       chg_start = 1'b0;
  logic [7:0] chg_amount = '0;
  logic       disp_ack = 1'b0;
  logic       disp_req;
  logic [4:0] disp_denom;
  logic [7:0] chg_remaining;
  logic       chg_busy, chg_done, chg_fault;

  change_dispenser #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst),
    .chg_start     (chg_start),
    .chg_amount    (chg_amount),
    .disp_ack      (disp_ack),
    .disp_req      (disp_req),
    .disp_denom    (disp_denom),
    .chg_remaining (chg_remaining),
    .chg_busy      (chg_busy),
    .chg_done      (chg_done),
    .chg_fault     (chg_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [4:0] denom;
    logic [7:0] rem;
  } exp_t;

  typedef enum {ACK_DELAY, ACK_CONST, ACK_NEVER} ack_mode_e;

  exp_t      exp_q[$];
  int        n_checks = 0;
  int        n_pass = 0;
  ack_mode_e ack_mode = ACK_DELAY;
  int        ack_delay_cfg = 2;  // negative: random 0..3 per request

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Greedy payout from the note list: each note is the largest that still fits.
  function automatic void model_push(input int amount);
    int   notes[5] = '{50, 20, 10, 5, 1};
    int   rem = amount;
    exp_t e;
    while (rem > 0) begin
      for (int i = 0; i < 5; i++) begin
        if (notes[i] <= rem) begin
          e.is_done = 1'b0;
          e.denom   = 5'(5'b10000 >> i);
          e.rem     = 8'(rem);
          exp_q.push_back(e);
          rem -= notes[i];
          break;
        end
      end
    end
    e.is_done = 1'b1;
    e.denom   = '0;
    e.rem     = '0;
    exp_q.push_back(e);
  endfunction

  // Monitor: checks each new request and each done pulse against the queue head.
  logic prev_req = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_req <= 1'b0;
    end else begin
      if (!disp_req) check("denom_zero_when_idle", disp_denom, 0);
      if (disp_req && !prev_req) begin
        check("req_expected", (exp_q.size() > 0 && !exp_q[0].is_done), 1);
        if (exp_q.size() > 0 && !exp_q[0].is_done) begin
          e = exp_q.pop_front();
          check("req_denom", disp_denom, e.denom);
          check("req_remaining", chg_remaining, e.rem);
        end
      end
      if (chg_done) begin
        check("done_expected", (exp_q.size() > 0 && exp_q[0].is_done), 1);
        if (exp_q.size() > 0 && exp_q[0].is_done) e = exp_q.pop_front();
      end
      prev_req <= disp_req;
    end
  end

  // Hopper model: acknowledges each request after a configurable delay.
  initial begin : ack_driver
    int cnt = 0;
    int cur = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        disp_ack = 1'b0;
        cnt = 0;
      end else begin
        case (ack_mode)
          ACK_CONST: disp_ack = 1'b1;
          ACK_NEVER: disp_ack = 1'b0;
          default: begin
            if (disp_req) begin
              if (cnt == 0) cur = (ack_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ack_delay_cfg;
              disp_ack = (cnt >= cur);
              cnt++;
            end else begin
              disp_ack = 1'b0;
              cnt = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, disp_req, 0);
    check({tag, "_denom"}, disp_denom, 0);
    check({tag, "_remaining"}, chg_remaining, 0);
    check({tag, "_busy"}, chg_busy, 0);
    check({tag, "_done"}, chg_done, 0);
    check({tag, "_fault"}, chg_fault, 0);
  endtask

  task automatic start_txn(input int amount, input bit push);
    @(posedge clk); #1;
    chg_start  = 1'b1;
    chg_amount = 8'(amount);
    if (push) model_push(amount);
    @(posedge clk); #1;
    chg_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!chg_busy && exp_q.size() == 0) begin
        check("txn_remaining_zero", chg_remaining, 0);
        return;
      end
    end
    check("idle_reached_busy", chg_busy, 0);
    check("idle_reached_sb_drained", exp_q.size(), 0);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (disp_req) return;
    end
    check("req_seen", disp_req, 1);
  endtask

  initial begin : main
    int rise[$];
    int len[$];
    int run;
    bit seen;

    #12;
    check_all_zero("reset");

    // Start on the very first edge after release; 87 = 50+20+10+5+1+1.
    @(posedge clk); #1;
    rst = 1'b0;
    ack_delay_cfg = 2;
    chg_start = 1'b1;
    chg_amount = 8'd87;
    model_push(87);
    @(posedge clk); #1;
    chg_start = 1'b0;
    check("first_edge_busy", chg_busy, 1);
    check("first_edge_remaining", chg_remaining, 87);
    wait_idle(2000);

    // Zero amount: done pulses two cycles after start, never a request.
    @(posedge clk); #1;
    chg_start = 1'b1;
    chg_amount = 8'd0;
    model_push(0);
    @(posedge clk); #1;
    chg_start = 1'b0;
    check("zero_c1_done", chg_done, 0);
    check("zero_c1_busy", chg_busy, 1);
    @(posedge clk); #1;
    check("zero_c2_done", chg_done, 1);
    check("zero_c2_req", disp_req, 0);
    @(posedge clk); #1;
    check("zero_c3_done", chg_done, 0);
    check("zero_c3_busy", chg_busy, 0);

    // A start arriving during GAP must not reload the amount.
    ack_delay_cfg = 1;
    start_txn(20, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (disp_req) seen = 1'b1;
      else if (seen) break;
    end
    check("gap_reached", (seen && !disp_req), 1);
    chg_start = 1'b1;
    chg_amount = 8'd5;
    @(posedge clk); #1;
    chg_start = 1'b0;
    check("gap_start_ignored_remaining", chg_remaining, 0);
    check("gap_start_ignored_busy", chg_busy, 1);
    wait_idle(500);

    // Reset in the middle of a request, then a fresh 1-yuan payout.
    ack_mode = ACK_NEVER;
    start_txn(30, 1'b1);
    wait_req(50);
    rst = 1'b1;
    #1;
    check_all_zero("midreq_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ack_mode = ACK_DELAY;
    ack_delay_cfg = -1;
    start_txn(1, 1'b1);
    wait_idle(500);

    // Hopper never acknowledges.
    ack_mode = ACK_NEVER;
    model_push(10);
    void'(exp_q.pop_back());
    start_txn(10, 1'b0);
    wait_req(50);
`ifdef CHG_TIMEOUT_EN
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_last_req", disp_req, 1);
    check("tmo_last_fault", chg_fault, 0);
    @(posedge clk); #1;
    check("tmo_fault", chg_fault, 1);
    check("tmo_req", disp_req, 0);
    check("tmo_denom", disp_denom, 0);
    check("tmo_remaining", chg_remaining, 10);
    check("tmo_busy", chg_busy, 1);
    chg_start = 1'b1;
    chg_amount = 8'd3;
    repeat (5) @(posedge clk);
    #1;
    chg_start = 1'b0;
    check("fault_sticky", chg_fault, 1);
    check("fault_remaining_kept", chg_remaining, 10);
`else
    repeat (TMO + 100) @(posedge clk);
    #1;
    check("noack_req_held", disp_req, 1);
    check("noack_denom_held", disp_denom, 5'b00100);
    check("noack_fault", chg_fault, 0);
    check("noack_remaining", chg_remaining, 10);
`endif
    rst = 1'b1;
    #1;
    check_all_zero("noack_reset");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    // Ack held high: 6 = 5+1, one-cycle requests. Between them come the GAP phase
    // and one selection cycle, so rising edges are GAP+2 cycles apart.
    ack_mode = ACK_CONST;
    start_txn(6, 1'b1);
    run = 0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      if (disp_req) begin
        if (run == 0) rise.push_back(t);
        run++;
      end else if (run != 0) begin
        len.push_back(run);
        run = 0;
      end
      if (!chg_busy) break;
    end
    check("const_ack_pulses", rise.size(), 2);
    if (len.size() == 2) begin
      check("const_ack_len0", len[0], 1);
      check("const_ack_len1", len[1], 1);
    end
    if (rise.size() == 2) check("const_ack_spacing", rise[1] - rise[0], GAP + 2);
    wait_idle(200);

    // Randomised payouts with random acknowledge latency.
    ack_mode = ACK_DELAY;
    ack_delay_cfg = -1;
    for (int n = 0; n < 25; n++) begin
      start_txn(int'($urandom_range(0, 255)), 1'b1);
      wait_idle(5000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4: idle cycles between consecutive note dispenses (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: cycles to wait for disp_ack before faulting (used only with CHG_TIMEOUT_EN).
REQ-003 SHALL have port sys_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port chg_start  input  1  start pulse; sampled only in IDLE.
REQ-006 SHALL have port chg_amount  input  8  change owed in yuan; sampled together with chg_start.
REQ-007 SHALL have port disp_ack  input  1  note-hopper acknowledge for the current request.
REQ-008 SHALL have port disp_req  output  1  note-hopper dispense request.
REQ-009 SHALL have port disp_denom  output  5  one-hot denomination {50,20,10,5,1}, MSB = 50.
REQ-010 SHALL have port chg_remaining  output  8  change still owed, for the 7-segment display path.
REQ-011 SHALL have port chg_busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port chg_done  output  1  one-cycle pulse when dispensing completes.
REQ-013 SHALL have port chg_fault  output  1  sticky hopper-timeout flag.

Function
REQ-014 SHALL implement states IDLE, SELECT, REQ, GAP, DONE, FAULT.
REQ-015 In IDLE with chg_start=1, the block SHALL load chg_amount into chg_remaining and enter SELECT on the next edge.
REQ-016 SHALL ignore chg_start in any state other than IDLE.
REQ-017 In SELECT, the block SHALL enter DONE if chg_remaining==0. Otherwise it SHALL latch the largest denomination <= chg_remaining into disp_denom and enter REQ.
REQ-018 In REQ, disp_req SHALL be 1 and disp_denom SHALL stay stable until disp_ack is sampled high.
REQ-019 On disp_ack in REQ, the block SHALL subtract the denomination value from chg_remaining (8-bit, never underflows by construction) and enter GAP.
REQ-020 The block SHALL deassert disp_req on the cycle after disp_ack is sampled.
REQ-021 disp_ack outside REQ SHALL be ignored.
REQ-022 disp_ack already high on the first REQ cycle SHALL be accepted, giving a one-cycle request.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles and then enter SELECT.
REQ-024 DONE SHALL last one cycle with chg_done=1, then return to IDLE.
REQ-025 chg_done SHALL go high 2 cycles after an accepted start with amount 0.
REQ-026 disp_denom SHALL be 0 whenever disp_req=0.
REQ-027 All outputs SHALL be registered.
REQ-028 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-029 On reset assertion at any time, including mid-request, the block SHALL immediately set state=IDLE and drive disp_req=0, disp_denom=0, chg_remaining=0, chg_busy=0, chg_done=0, chg_fault=0; the GAP and timeout counters SHALL also clear.
REQ-030 After reset release, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-031 With macro CHG_TIMEOUT_EN defined:
- a counter SHALL run while in REQ;
- if disp_ack has not arrived after TIMEOUT_CYCLES cycles, the block SHALL enter FAULT with disp_req=0 and chg_fault=1, and chg_remaining SHALL keep the unpaid amount;
- FAULT SHALL be left only by reset.
REQ-032 Without CHG_TIMEOUT_EN:
- no timeout counter SHALL exist;
- REQ SHALL wait for disp_ack indefinitely;
- chg_fault SHALL be tied to 0.

Structure
REQ-033 A shared package SHALL hold the following, reused by the upstream state-transition block:
- the state encoding;
- the one-hot denomination constants;
- the denomination value constants 50/20/10/5/1.
REQ-034 Greedy selection SHALL be a combinational sub-module denom_select (8-bit amount in; one-hot denomination and 8-bit value out).

Verification
REQ-035 Start with amount 87, ack 2 cycles after each request -> denominations 50,20,10,5,1,1 in order; chg_remaining steps 87,37,17,7,2,1,0; chg_done pulses once.
REQ-036 Start with amount 0 -> no disp_req; chg_done high for 1 cycle, 2 cycles after start.
REQ-037 Start with amount 20, then a second start with amount 5 during GAP -> exactly one 20 dispensed; the second start is ignored.
REQ-038 Reset asserted while disp_req=1 with amount 30 outstanding -> all outputs 0 at once; after release, start with amount 1 -> one 1-yuan dispense.
REQ-039 With CHG_TIMEOUT_EN, start with amount 10 and never ack -> after 1000 REQ cycles chg_fault=1, disp_req=0, chg_remaining=10. Without the macro -> disp_req stays high.
REQ-040 disp_ack held constantly high, amount 6 -> denominations 5 then 1, each request lasting one cycle, separated by GAP_CYCLES.
